// File: rtl/ls_register_universal.sv
// Parametrised universal shift register with a serial fill counter and FULL/OVF flags.
// One mux cell per bit picks the next value; the top decodes MODE and owns the counter.

module ls_bit_cell (
    input  logic q_self,
    input  logic from_lo,
    input  logic from_hi,
    input  logic pin_bit,
    input  logic sel_lo,
    input  logic sel_hi,
    input  logic sel_pin,
    input  logic sel_clr,
    output logic d
);
    // Selects are one-hot or all zero; all zero means hold.
    always_comb begin
        d = q_self;
        if (sel_lo)       d = from_lo;
        else if (sel_hi)  d = from_hi;
        else if (sel_pin) d = pin_bit;
        else if (sel_clr) d = 1'b0;
    end
endmodule

module ls_register_universal #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              CW      = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic             SIN_L,
    input  logic             SIN_R,
    input  logic [WIDTH-1:0] PIN,
    output logic [WIDTH-1:0] Q,
    output logic             SOUT_L,
    output logic             SOUT_R,
    output logic [CW-1:0]    CNT,
    output logic             FULL,
    output logic             OVF
);
    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_SHL  = 3'b001,
        M_SHR  = 3'b010,
        M_ROL  = 3'b011,
        M_ROR  = 3'b100,
        M_LOAD = 3'b101,
        M_CLR  = 3'b110,
        M_RSV  = 3'b111
    } mode_t;

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    mode_t            mode;
    logic             is_shift, is_left, is_right, is_load, is_clr;
    logic [WIDTH-1:0] lo_in, hi_in, q_d;
    logic [CW-1:0]    cnt_d;
    logic             ovf_d;

    assign mode     = mode_t'(MODE);
    assign is_left  = (mode == M_SHL) || (mode == M_ROL);
    assign is_right = (mode == M_SHR) || (mode == M_ROR);
    assign is_shift = (mode == M_SHL) || (mode == M_SHR);
    assign is_load  = (mode == M_LOAD);
    assign is_clr   = (mode == M_CLR);

    // Edge bits take the serial input on a shift, the wrapped-around bit on a rotate.
    assign lo_in = {Q[WIDTH-2:0], (mode == M_ROL) ? Q[WIDTH-1] : SIN_L};
    assign hi_in = {(mode == M_ROR) ? Q[0] : SIN_R, Q[WIDTH-1:1]};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ls_bit_cell u_cell (
            .q_self (Q[i]),
            .from_lo(lo_in[i]),
            .from_hi(hi_in[i]),
            .pin_bit(PIN[i]),
            .sel_lo (is_left),
            .sel_hi (is_right),
            .sel_pin(is_load),
            .sel_clr(is_clr),
            .d      (q_d[i])
        );
    end

    // Shifting past a full word still moves data; it only raises the sticky overrun.
    always_comb begin
        cnt_d = CNT;
        ovf_d = OVF;
        if (is_shift) begin
            if (CNT == CNT_MAX) ovf_d = 1'b1;
            else                cnt_d = CNT + CW'(1);
        end else if (is_load || is_clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Q    <= RST_VAL;
            CNT  <= '0;
            FULL <= 1'b0;
            OVF  <= 1'b0;
        end else if (EN) begin
            Q    <= q_d;
            CNT  <= cnt_d;
            FULL <= (cnt_d == CNT_MAX);
            OVF  <= ovf_d;
        end
    end

    assign SOUT_L = Q[WIDTH-1];
    assign SOUT_R = Q[0];
endmodule

// File: doc/ls_register_universal.md
Name: ls_register_universal

Overview:
Parametrised universal shift register, successor to the fixed 4-bit serial-in left-shift register. Supports hold, left/right shift, left/right rotate, parallel load and synchronous clear, selected per cycle. A fill counter tracks serial bits shifted in since the last load or clear. FULL and sticky OVF flags let a serial-to-parallel consumer know when a word is complete or has been overrun. With WIDTH=4 and MODE=shift-left it is cycle-equivalent to the 4-bit predecessor, apart from reset polarity.

Parameters:
WIDTH, 8, register width in bits (2..32)
RST_VAL, 0, value of Q after reset (WIDTH bits)

Ports:
CLK  in  1  clock, rising-edge
RST  in  1  asynchronous reset, active-low
EN  in  1  clock enable; 0 = hold everything
MODE  in  3  operation select (see Behaviour)
SIN_L  in  1  serial input entering bit 0 on left shift
SIN_R  in  1  serial input entering bit WIDTH-1 on right shift
PIN  in  WIDTH  parallel load data
Q  out  WIDTH  register contents
SOUT_L  out  1  Q[WIDTH-1], combinational from Q
SOUT_R  out  1  Q[0], combinational from Q
CNT  out  $clog2(WIDTH+1)  serial bits shifted in since last load/clear, saturating at WIDTH
FULL  out  1  registered; 1 when CNT==WIDTH
OVF  out  1  sticky; set by a shift while FULL

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RST.
- Reset (RST=0), asynchronous and immediate: Q=RST_VAL, CNT=0, FULL=0, OVF=0. Holds while RST is low. Release is sampled at the next CLK edge.
- All state updates on rising CLK, and only when EN=1. When EN=0, Q, CNT, FULL and OVF all hold.
- MODE encoding, single-cycle latency (takes effect at the edge, visible after it):
  - 000 hold: Q unchanged.
  - 001 shift left: Q <= {Q[WIDTH-2:0], SIN_L}.
  - 010 shift right: Q <= {SIN_R, Q[WIDTH-1:1]}.
  - 011 rotate left: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
  - 100 rotate right: Q <= {Q[0], Q[WIDTH-1:1]}.
  - 101 parallel load: Q <= PIN.
  - 110 sync clear: Q <= 0. This writes zero, not RST_VAL.
  - 111 reserved: behaves as hold.
- Counter and flags:
  - Shift (001/010) with CNT<WIDTH: CNT <= CNT+1.
  - Shift with CNT==WIDTH: CNT stays WIDTH and OVF <= 1. Q still shifts; data is not blocked.
  - Load (101) or clear (110): CNT <= 0, FULL <= 0, OVF <= 0.
  - Rotate, hold and reserved: CNT, FULL and OVF unchanged.
  - FULL is updated on the same edge as CNT: FULL=1 exactly while CNT==WIDTH.
- Left and right shifts both count toward the same counter. Mixing directions is legal and counted.
- SIN_L is ignored in every mode except 001. SIN_R is ignored in every mode except 010. PIN is ignored in every mode except 101.
- Reset mid-shift sequence: all state is lost immediately, with no partial completion.
- SOUT_L and SOUT_R have no extra latency. They reflect Q after each edge.
- No X propagation: every output is defined from reset onward.

Test Plan:
- WIDTH=4, RST=0 for 2 cycles then 1; MODE=001, EN=1; SIN_L sequence 1,0,1,1 -> Q after each edge: 0001, 0010, 0101, 1011. CNT goes 1..4. FULL=1 after the 4th edge.
- WIDTH=8, load PIN=8'hA5 -> Q=A5, CNT=0. Rotate left 8 times -> Q returns to A5, CNT=0 throughout. Rotate right once -> Q=D2.
- WIDTH=8, clear then 8 right shifts with SIN_R=1 -> Q=FF, FULL=1, OVF=0. A 9th shift -> Q=FF, CNT=8, OVF=1. Then a load -> CNT=0, FULL=0, OVF=0.
- EN=0 during MODE=001 with SIN_L toggling for 5 cycles -> Q, CNT, FULL and OVF unchanged.
- Assert RST low asynchronously between edges mid-sequence (Q=5C, CNT=3, RST_VAL=8'h3C) -> Q=3C and CNT=0 immediately, before the next edge. MODE=110 afterwards -> Q=00.
- MODE=111 with PIN=FF and SIN_L=1 -> behaves as hold; Q unchanged.
